// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and constants for the INTA/EOI sequencer
package pic_pkg;

  localparam int unsigned CNT_W = 4;
  localparam logic [7:0] OCW2_NS_EOI = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACK1    = 3'd1,
    ST_GAP1    = 3'd2,
    ST_ACK2    = 3'd3,
    ST_SERVICE = 3'd4,
    ST_EOI_WR  = 3'd5,
    ST_RECOV   = 3'd6
  } state_e;

  // Counter reload value for a phase lasting w cycles (counter runs w-1 .. 0).
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned w);
    return CNT_W'(w - 1);
  endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// rtl/inta_sequencer_if.sv - PIC/CPU side signal bundle of the INTA sequencer
interface inta_sequencer_if;

  logic       INT;
  logic       IF;
  logic       AEOI;
  logic [7:0] D;
  logic       eoi_req;
  logic       INTA;
  logic       WR;
  logic [7:0] DOUT;
  logic [7:0] vec;
  logic       vec_valid;
  logic       busy;

  modport master (
    input  INT, IF, AEOI, D, eoi_req,
    output INTA, WR, DOUT, vec, vec_valid, busy
  );

  modport slave (
    output INT, IF, AEOI, D, eoi_req,
    input  INTA, WR, DOUT, vec, vec_valid, busy
  );

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous level
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - two-pulse INTA vector fetch with optional EOI write-back
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  inta_sequencer_if.master  bus
);

  localparam logic [CNT_W-1:0] PULSE_LD = cnt_load(PULSE_W);
  localparam logic [CNT_W-1:0] GAP_LD   = cnt_load(GAP_W);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             int_s;
  logic             cnt_zero;
  logic             vec_load;

  logic             inta_q;
  logic             wr_q;
  logic [7:0]       dout_q;
  logic [7:0]       vec_q;
  logic             vec_valid_q;
  logic             busy_q;

  sync2 u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.INT),
    .q_o   (int_s)
  );

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Once ACK1 is entered the sequence runs to completion regardless of INT_s/IF.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vec_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (int_s && bus.IF) begin
          state_d = ST_ACK1;
          cnt_d   = PULSE_LD;
        end
      end
      ST_ACK1: begin
        if (cnt_zero) begin
          state_d = ST_GAP1;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP1: begin
        if (cnt_zero) begin
          state_d = ST_ACK2;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK2: begin
        if (cnt_zero) begin
          vec_load = 1'b1;
          if (bus.AEOI) begin
            state_d = ST_RECOV;
            cnt_d   = GAP_LD;
          end else begin
            state_d = ST_SERVICE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SERVICE: begin
        cnt_d = '0;
        if (bus.eoi_req) begin
          state_d = ST_EOI_WR;
          cnt_d   = PULSE_LD;
        end
      end
      ST_EOI_WR: begin
        if (cnt_zero) begin
          state_d = ST_RECOV;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RECOV: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are decoded from the next state so they line up with state_q and come straight off flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_q      <= 1'b0;
      wr_q        <= 1'b0;
      dout_q      <= 8'h00;
      vec_q       <= 8'h00;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      inta_q      <= (state_d == ST_ACK1) || (state_d == ST_ACK2);
      wr_q        <= (state_d == ST_EOI_WR);
      dout_q      <= (state_d == ST_EOI_WR) ? OCW2_NS_EOI : 8'h00;
      vec_valid_q <= vec_load;
      busy_q      <= (state_d != ST_IDLE);
      if (vec_load) begin
        vec_q <= bus.D;
      end
    end
  end

  assign bus.INTA      = inta_q;
  assign bus.WR        = wr_q;
  assign bus.DOUT      = dout_q;
  assign bus.vec       = vec_q;
  assign bus.vec_valid = vec_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// tb/tb_inta_sequencer.sv - self-checking bench for inta_sequencer
module tb_inta_sequencer;

  localparam int PW = 2;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  inta_sequencer_if ifa ();
  inta_sequencer_if ifb ();

  inta_sequencer #(.PULSE_W(PW), .GAP_W(GW)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  inta_sequencer #(.PULSE_W(1), .GAP_W(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("inta_wr_excl_a", 32'(ifa.INTA & ifa.WR), 32'd0);
    chk("inta_wr_excl_b", 32'(ifb.INTA & ifb.WR), 32'd0);
  endtask

  // Reference: INTA = PW high, GW low, PW high; vec_valid next; then either
  // GW recovery (AEOI) or SERVICE until eoi_req, PW of WR/0x20, GW recovery.
  task automatic run_seq(input logic [7:0] d, input bit aeoi, input int eoi_delay,
                         input bit drop_int, input bit eoi_in_ack2, input bit keep_int);
    bit exp_q[$];
    int n;
    for (int i = 0; i < PW; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < GW; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < PW; i++) exp_q.push_back(1'b1);
    ifa.D = d; ifa.AEOI = aeoi; ifa.IF = 1'b1; ifa.INT = 1'b1;
    n = 0;
    while (!ifa.INTA && n < 20) begin step(); n++; end
    chk("ack1_start", 32'(ifa.INTA), 32'd1);
    if (!ifa.INTA) return;
    foreach (exp_q[i]) begin
      if (drop_int && i == PW) ifa.INT = 1'b0;
      if (eoi_in_ack2) ifa.eoi_req = (i == PW + GW);
      chk("inta_shape", 32'(ifa.INTA), 32'(exp_q[i]));
      chk("busy_in_ack", 32'(ifa.busy), 32'd1);
      step();
    end
    ifa.eoi_req = 1'b0;
    chk("vec_valid_pulse", 32'(ifa.vec_valid), 32'd1);
    chk("vec_value", 32'(ifa.vec), 32'(d));
    chk("inta_low_after", 32'(ifa.INTA), 32'd0);
    if (!keep_int) ifa.INT = 1'b0;
    if (aeoi) begin
      for (int i = 0; i < GW - 1; i++) begin
        step();
        chk("recov_no_wr", 32'(ifa.WR), 32'd0);
        chk("recov_busy", 32'(ifa.busy), 32'd1);
      end
    end else begin
      for (int j = 0; j < eoi_delay; j++) begin
        step();
        chk("service_wait_wr", 32'(ifa.WR), 32'd0);
        chk("service_busy", 32'(ifa.busy), 32'd1);
      end
      ifa.eoi_req = 1'b1;
      step();
      ifa.eoi_req = 1'b0;
      for (int i = 0; i < PW; i++) begin
        chk("eoi_wr", 32'(ifa.WR), 32'd1);
        chk("eoi_dout", 32'(ifa.DOUT), 32'h20);
        step();
      end
      for (int i = 0; i < GW - 1; i++) begin
        chk("recov_wr", 32'(ifa.WR), 32'd0);
        chk("recov_dout", 32'(ifa.DOUT), 32'h00);
        chk("recov_busy", 32'(ifa.busy), 32'd1);
        step();
      end
      chk("recov_last_wr", 32'(ifa.WR), 32'd0);
    end
    step();
    chk("idle_busy", 32'(ifa.busy), 32'd0);
    chk("idle_vec_valid", 32'(ifa.vec_valid), 32'd0);
    chk("idle_dout", 32'(ifa.DOUT), 32'h00);
  endtask

  initial begin
    int  n;
    int  highs;
    logic [7:0] rd;
    bit  pat_b[3];

    rst_n = 1'b0;
    ifa.INT = 1'b0; ifa.IF = 1'b0; ifa.AEOI = 1'b0; ifa.D = 8'h00; ifa.eoi_req = 1'b0;
    ifb.INT = 1'b0; ifb.IF = 1'b0; ifb.AEOI = 1'b0; ifb.D = 8'h00; ifb.eoi_req = 1'b0;
    #3;
    chk("rst_inta", 32'(ifa.INTA), 32'd0);
    chk("rst_wr", 32'(ifa.WR), 32'd0);
    chk("rst_dout", 32'(ifa.DOUT), 32'h00);
    chk("rst_vec", 32'(ifa.vec), 32'h00);
    chk("rst_vec_valid", 32'(ifa.vec_valid), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_busy_b", 32'(ifb.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Basic sequence with EOI, INT left high so the next ACK1 follows IDLE.
    run_seq(8'h0F, 1'b0, 3, 1'b0, 1'b0, 1'b1);
    step();
    chk("reack_after_eoi", 32'(ifa.INTA), 32'd1);
    run_seq(8'h0B, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    chk("aeoi_idle_inta", 32'(ifa.INTA), 32'd0);
    chk("aeoi_idle_busy", 32'(ifa.busy), 32'd0);

    // IF gating: INT high but IF low must never acknowledge.
    ifa.IF = 1'b0; ifa.INT = 1'b1;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ifa.INTA || ifa.busy) highs++;
    end
    chk("if_low_no_inta", 32'(highs), 32'd0);
    ifa.IF = 1'b1;
    n = 0;
    while (!ifa.INTA && n < 3) begin step(); n++; end
    chk("if_release_ack1", 32'(ifa.INTA), 32'd1);
    run_seq(8'h5A, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    repeat (3) step();

    // INT dropped during GAP1, eoi_req during ACK2 must be ignored.
    run_seq(8'h0F, 1'b0, 4, 1'b1, 1'b1, 1'b0);
    repeat (3) step();

    // Reset during ACK2.
    ifa.D = 8'hC3; ifa.AEOI = 1'b0; ifa.IF = 1'b1; ifa.INT = 1'b1;
    n = 0;
    while (!ifa.INTA && n < 20) begin step(); n++; end
    chk("rst_seq_start", 32'(ifa.INTA), 32'd1);
    repeat (PW + GW) step();
    chk("rst_seq_in_ack2", 32'(ifa.INTA), 32'd1);
    rst_n = 1'b0;
    ifa.INT = 1'b0;
    #1;
    chk("midrst_inta", 32'(ifa.INTA), 32'd0);
    chk("midrst_busy", 32'(ifa.busy), 32'd0);
    chk("midrst_vec", 32'(ifa.vec), 32'h00);
    chk("midrst_vec_valid", 32'(ifa.vec_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    chk("postrst_idle_busy", 32'(ifa.busy), 32'd0);
    chk("postrst_idle_inta", 32'(ifa.INTA), 32'd0);
    run_seq(8'h3C, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();

    // Randomized sequences against the reference waveform.
    for (int k = 0; k < 6; k++) begin
      bit keep;
      rd   = 8'($urandom);
      keep = (k < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_seq(rd, 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), keep);
      if (!keep) begin
        repeat (3) step();
        chk("rand_idle_inta", 32'(ifa.INTA), 32'd0);
      end
    end

    // Minimum widths: PULSE_W = GAP_W = 1.
    pat_b = '{1'b1, 1'b0, 1'b1};
    rd = 8'($urandom);
    ifb.D = rd; ifb.AEOI = 1'b0; ifb.IF = 1'b1; ifb.INT = 1'b1;
    n = 0;
    while (!ifb.INTA && n < 20) begin step(); n++; end
    chk("b_ack1_start", 32'(ifb.INTA), 32'd1);
    ifb.INT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("b_inta_shape", 32'(ifb.INTA), 32'(pat_b[i]));
      step();
    end
    chk("b_vec_valid", 32'(ifb.vec_valid), 32'd1);
    chk("b_vec", 32'(ifb.vec), 32'(rd));
    ifb.eoi_req = 1'b1;
    step();
    ifb.eoi_req = 1'b0;
    chk("b_wr_on", 32'(ifb.WR), 32'd1);
    chk("b_dout", 32'(ifb.DOUT), 32'h20);
    step();
    chk("b_wr_off", 32'(ifb.WR), 32'd0);
    chk("b_recov_busy", 32'(ifb.busy), 32'd1);
    step();
    chk("b_idle_busy", 32'(ifb.busy), 32'd0);
    step();
    chk("b_idle_inta", 32'(ifb.INTA), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 Parameter PULSE_W, default 2: INTA/WR high width in clk cycles, legal 1..15.
REQ-002 Parameter GAP_W, default 2: low gap between pulses and post-EOI recovery, in clk cycles, legal 1..15.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 INT  in  1  interrupt request from PIC priority resolver, asynchronous to clk.
REQ-006 IF  in  1  CPU interrupt-enable flag.
REQ-007 AEOI  in  1  PIC in automatic-EOI mode; suppresses EOI write.
REQ-008 D  in  8  PIC data bus, carries vector during second INTA pulse.
REQ-009 eoi_req  in  1  one-cycle pulse: handler finished, issue EOI.
REQ-010 INTA  out  1  active-high interrupt-acknowledge pulse to PIC.
REQ-011 WR  out  1  active-high command-write strobe to PIC.
REQ-012 DOUT  out  8  command byte driven with WR.
REQ-013 vec  out  8  captured interrupt vector.
REQ-014 vec_valid  out  1  one-cycle pulse, vec valid.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 INT SHALL pass through a 2-flop synchronizer (INT_s); INT to INT_s latency 2 cycles.
REQ-017 States: IDLE, ACK1, GAP1, ACK2, SERVICE, EOI_WR, RECOV.
REQ-018 IDLE: INT_s=1 and IF=1 -> ACK1 next cycle; otherwise stay; no outputs asserted.
REQ-019 ACK1: INTA=1 for exactly PULSE_W cycles -> GAP1.
REQ-020 GAP1: INTA=0 for exactly GAP_W cycles -> ACK2.
REQ-021 ACK2: INTA=1 for exactly PULSE_W cycles; D SHALL be sampled into vec on the last ACK2 cycle.
REQ-022 vec_valid SHALL pulse for one cycle, the cycle after ACK2 ends; vec holds until next capture.
REQ-023 After ACK2: AEOI=1 -> RECOV; AEOI=0 -> SERVICE.
REQ-024 SERVICE: wait for eoi_req=1 -> EOI_WR; no timeout.
REQ-025 EOI_WR: WR=1 and DOUT=8'h20 (non-specific EOI) for exactly PULSE_W cycles -> RECOV.
REQ-026 DOUT SHALL be 8'h00 whenever WR=0.
REQ-027 RECOV: all strobes low for GAP_W cycles -> IDLE, so the PIC can update INT before re-evaluation.
REQ-028 Once ACK1 is entered, the two-pulse sequence SHALL always complete, even if INT_s or IF drops; vec takes whatever D carries (spurious IR7 vector accepted).
REQ-029 eoi_req outside SERVICE SHALL be ignored (not latched).
REQ-030 INT_s or IF changes during SERVICE/EOI_WR/RECOV SHALL have no effect until IDLE.
REQ-031 One shared down-counter, 4 bits, loaded with PULSE_W-1 or GAP_W-1 on state entry; state advances when counter is 0.
REQ-032 INTA and WR SHALL never be high in the same cycle, and both SHALL be registered outputs (glitch-free).

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, counter 0, synchronizer flops 0, INTA=0, WR=0, DOUT=8'h00, vec=8'h00, vec_valid=0, busy=0.
REQ-034 Reset mid-pulse SHALL drop INTA/WR asynchronously; after release, a new sequence starts only from IDLE.

Structure
REQ-035 Shared package pic_pkg SHALL hold the state enumeration, OCW2_NS_EOI = 8'h20, and counter width 4.
REQ-036 One sub-module, sync2 (2-flop synchronizer), SHALL be instantiated for INT.

Verification
REQ-037 Defaults, IF=1, AEOI=0, D=8'h0F; raise INT -> INTA high 2 cycles, low 2, high 2; vec=8'h0F; vec_valid 1 cycle; busy stays high in SERVICE.
REQ-038 In SERVICE, pulse eoi_req -> WR high 2 cycles with DOUT=8'h20, then 2 idle cycles, then IDLE; INT still high -> new ACK1 begins.
REQ-039 AEOI=1, D=8'h0B -> vec=8'h0B, no WR pulse, return to IDLE after RECOV.
REQ-040 IF=0 with INT=1 -> no INTA for 20 cycles; set IF=1 -> ACK1 starts within 3 cycles.
REQ-041 Drop INT during GAP1, D=8'h0F -> ACK2 still issued, vec=8'h0F; eoi_req during ACK2 ignored; SERVICE waits.
REQ-042 Assert rst_n=0 during ACK2 -> INTA=0 same cycle, vec=8'h00, busy=0; PULSE_W=1/GAP_W=1 run -> pulse widths exactly 1.
